// File: rtl/ts_capture_pkg.sv
// ts_capture_pkg: shared constants and FSM encoding for the TS capture engine
package ts_capture_pkg;
  localparam int ADDR_PID = 2;
  localparam int ADDR_READ_REQUEST = 4;
  localparam int ADDR_DROP_COUNT = 5;
  localparam int ADDR_TS_DATA_BASE = 128;
  localparam int PACK_BYTE_SIZE = 188;
  localparam int PACK_WORD_SIZE = 47;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  typedef enum logic [2:0] {ST_IDLE, ST_HUNT, ST_HEADER, ST_CAPTURE, ST_DONE} state_t;
endpackage

// File: rtl/ts_capture_buf.sv
// ts_capture_buf: 47x32 packet buffer, byte-lane write port, registered read port
module ts_capture_buf
  import ts_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [7:0]  wr_idx,
  input  logic [7:0]  wr_byte,
  input  logic        re,
  input  logic [5:0]  rd_idx,
  output logic [31:0] rd_word
);
  logic [31:0] mem [PACK_WORD_SIZE];
  // byte n lands in word n>>2, lane n[1:0]; reads are captured only on re
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PACK_WORD_SIZE; i++) mem[i] <= '0;
      rd_word <= '0;
    end else begin
      if (we) mem[wr_idx[7:2]][{wr_idx[1:0], 3'b000} +: 8] <= wr_byte;
      if (re) rd_word <= mem[rd_idx];
    end
  end
endmodule

// File: rtl/ts_capture.sv
// ts_capture: hunts the TS for one packet of a programmed PID and exposes it via the register port
module ts_capture
  import ts_capture_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ts_data,
  input  logic                          ts_valid,
  input  logic                          ts_sync,
  input  logic                          wen,
  input  logic [OPT_MEM_ADDR_BITS-1:0]  waddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata,
  input  logic                          ren,
  input  logic [OPT_MEM_ADDR_BITS-1:0]  raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rdata,
  output logic                          capture_done
);
  localparam int A = OPT_MEM_ADDR_BITS;
  localparam logic [A-1:0] A_PID = A'(ADDR_PID);
  localparam logic [A-1:0] A_RR = A'(ADDR_READ_REQUEST);
  localparam logic [A-1:0] A_DROP = A'(ADDR_DROP_COUNT);
  localparam logic [A-1:0] A_BASE = A'(ADDR_TS_DATA_BASE);
  localparam logic [7:0] LAST_IDX = 8'(PACK_BYTE_SIZE - 1);
  state_t state;
  logic [7:0] byte_idx;
  logic [4:0] b1;
  logic [12:0] pid, cur_pid;
  logic pid_en, cur_en;
  logic [15:0] drop_cnt;
  logic arm, v, sync47, in_pkt, buf_we, in_buf, sel_buf;
  logic [7:0] buf_idx;
  logic [A-1:0] roff;
  logic [31:0] rd_val, reg_word, buf_word;
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:17], wdata[15:13]};
  assign arm = wen && waddr == A_RR;
  assign v = ts_valid && !arm;
  assign sync47 = ts_sync && ts_data == TS_SYNC_BYTE;
  assign in_pkt = state == ST_HEADER || state == ST_CAPTURE;
  assign buf_we = v && ((state == ST_HUNT && sync47) || (in_pkt && (!ts_sync || sync47)));
  assign buf_idx = ts_sync ? 8'd0 : byte_idx;
  assign roff = raddr - A_BASE;
  assign in_buf = raddr >= A_BASE && roff < A'(PACK_WORD_SIZE);
  assign capture_done = state == ST_DONE;
  assign rdata = sel_buf ? buf_word : reg_word;
  // register-side read value for non-buffer addresses
  always_comb
    rd_val = raddr == A_PID  ? {15'b0, pid_en, 3'b0, pid} :
             raddr == A_RR   ? {31'b0, capture_done} :
             raddr == A_DROP ? {16'b0, drop_cnt} : 32'd0;
  // PID register, arming, drop counter and the packet hunt FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      byte_idx <= '0;
      b1 <= '0;
      pid <= '0;
      pid_en <= 1'b0;
      cur_pid <= '0;
      cur_en <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wen && waddr == A_PID) begin
        pid_en <= wdata[16];
        pid <= wdata[12:0];
      end
      if (arm) begin
        cur_pid <= pid;
        cur_en <= pid_en;
        state <= ST_HUNT;
        byte_idx <= '0;
      end else if (v && in_pkt && ts_sync) begin
        drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + 16'd1;
        state <= sync47 ? ST_HEADER : ST_HUNT;
        byte_idx <= sync47 ? 8'd1 : 8'd0;
      end else if (v && state == ST_HUNT && sync47) begin
        state <= ST_HEADER;
        byte_idx <= 8'd1;
      end else if (v && state == ST_HEADER && byte_idx == 8'd1) begin
        b1 <= ts_data[4:0];
        byte_idx <= 8'd2;
      end else if (v && state == ST_HEADER) begin
        state <= (!cur_en || {b1, ts_data} == cur_pid) ? ST_CAPTURE : ST_HUNT;
        byte_idx <= (!cur_en || {b1, ts_data} == cur_pid) ? 8'd3 : 8'd0;
      end else if (v && state == ST_CAPTURE) begin
        state <= byte_idx == LAST_IDX ? ST_DONE : ST_CAPTURE;
        byte_idx <= byte_idx + 8'd1;
      end
    end
  end
  // read data register; buffer words come from the buffer's own read register
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_word <= '0;
      sel_buf <= 1'b0;
    end else if (ren) begin
      reg_word <= rd_val;
      sel_buf <= in_buf;
    end
  end
  ts_capture_buf u_buf (
    .clk(clk),
    .rst(rst),
    .we(buf_we),
    .wr_idx(buf_idx),
    .wr_byte(ts_data),
    .re(ren && in_buf),
    .rd_idx(roff[5:0]),
    .rd_word(buf_word)
  );
endmodule

// File: tb/tb_ts_capture.sv
// tb_ts_capture: randomized stream checked against a queue-based packet model
module tb_ts_capture;
  logic clk = 0, rst = 1;
  logic [7:0] ts_data = 0;
  logic ts_valid = 0, ts_sync = 0, wen = 0, ren = 0;
  logic [9:0] waddr = 0, raddr = 0;
  logic [31:0] wdata = 0, rdata, tmp;
  logic capture_done;
  int n_chk = 0, n_err = 0;
  bit chk_on = 0, rnd_rd = 0;

  ts_capture dut (
    .clk(clk), .rst(rst), .ts_data(ts_data), .ts_valid(ts_valid), .ts_sync(ts_sync),
    .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
    .rdata(rdata), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  // behavioural model: packet being gathered is a queue of bytes
  logic [7:0] m_buf [188];
  logic [7:0] cur [$];
  bit m_active, m_done, m_pid_en, m_cur_en;
  logic [12:0] m_pid, m_cur_pid;
  int m_drop;
  logic [31:0] exp_rd;
  logic [7:0] pkt [188];

  function automatic logic [31:0] m_read(input logic [9:0] a);
    int k;
    if (a == 10'd2) return {15'b0, m_pid_en, 3'b0, m_pid};
    if (a == 10'd4) return {31'b0, m_done};
    if (a == 10'd5) return {16'b0, m_drop[15:0]};
    if (a >= 10'd128 && a <= 10'd174) begin
      k = int'(a) - 128;
      return {m_buf[4*k+3], m_buf[4*k+2], m_buf[4*k+1], m_buf[4*k]};
    end
    return 32'd0;
  endfunction

  task automatic m_byte(input bit s, input logic [7:0] d);
    if (s && cur.size() != 0) begin
      if (m_drop < 65535) m_drop++;
      cur.delete();
    end
    if (s) begin
      if (d == 8'h47) begin
        cur.push_back(d);
        m_buf[0] = d;
      end
    end else if (cur.size() != 0) begin
      m_buf[cur.size()] = d;
      cur.push_back(d);
      if (cur.size() == 3 && m_cur_en && {cur[1][4:0], cur[2]} != m_cur_pid) cur.delete();
      else if (cur.size() == 188) begin
        m_done = 1;
        m_active = 0;
        cur.delete();
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_buf[i]) m_buf[i] = 0;
      cur.delete();
      m_active = 0; m_done = 0; m_pid_en = 0; m_cur_en = 0;
      m_pid = 0; m_cur_pid = 0; m_drop = 0; exp_rd = 0;
    end else begin
      if (ren) exp_rd = m_read(raddr);
      if (wen && waddr == 10'd2) begin
        m_pid_en = wdata[16];
        m_pid = wdata[12:0];
      end
      if (wen && waddr == 10'd4) begin
        m_cur_pid = m_pid; m_cur_en = m_pid_en;
        m_active = 1; m_done = 0;
        cur.delete();
      end else if (ts_valid && m_active) m_byte(ts_sync, ts_data);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) if (chk_on) begin
    check("capture_done", {31'b0, capture_done}, {31'b0, m_done});
    check("rdata", rdata, exp_rd);
  end

  function automatic logic [9:0] pick();
    int r = $urandom_range(0, 9);
    return r < 6 ? 10'(128 + $urandom_range(0, 46)) : r == 6 ? 10'd2 : r == 7 ? 10'd4 :
           r == 8 ? 10'd5 : 10'($urandom_range(0, 1023));
  endfunction

  task automatic drive(input bit v, input bit s, input logic [7:0] d);
    @(negedge clk);
    ts_valid = v; ts_sync = s; ts_data = d; wen = 0;
    if (rnd_rd) begin
      ren = 1'($urandom_range(0, 1));
      raddr = pick();
    end else ren = 0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input bit v = 0,
                    input bit s = 0, input logic [7:0] b = 0);
    @(negedge clk);
    wen = 1; waddr = a; wdata = d; ts_valid = v; ts_sync = s; ts_data = b; ren = 0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    ren = 1; raddr = a; wen = 0; ts_valid = 0; ts_sync = 0;
    @(negedge clk);
    ren = 0;
    d = rdata;
  endtask

  task automatic send_byte(input bit s, input logic [7:0] d, input int gap);
    int g = gap < 0 ? $urandom_range(0, 2) : gap;
    repeat (g) drive(0, 1'($urandom_range(0, 1)), 8'($urandom));
    drive(1, s, d);
  endtask

  task automatic build(input logic [12:0] pid, input int mode);
    for (int n = 0; n < 188; n++)
      pkt[n] = mode == 0 ? 8'(n) : mode == 1 ? 8'(n) ^ 8'h5A : 8'($urandom);
    pkt[0] = 8'h47; pkt[1] = {3'b0, pid[12:8]}; pkt[2] = pid[7:0]; pkt[3] = 8'h10;
  endtask

  task automatic send(input int first, input int last, input int gap);
    for (int n = first; n <= last; n++) send_byte(n == 0, pkt[n], gap);
  endtask

  task automatic read_all();
    for (int k = 128; k <= 174; k++) rd(10'(k), tmp);
  endtask

  task automatic std_stream(input int gap);
    build(13'h0191, 0); send(0, 187, gap);
    build(13'h157F, 0); send(0, 187, gap);
    build(13'h0191, 0); send(0, 187, gap);
    drive(0, 0, 0);
  endtask

  logic [12:0] pids [3] = '{13'h157F, 13'h0191, 13'h0000};

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk_on = 1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_done", {31'b0, capture_done}, 32'd0);
    rd(10'd4, tmp); check("reset_rr", tmp, 32'd0);
    rd(10'd2, tmp); check("reset_pid", tmp, 32'd0);
    rd(10'd5, tmp); check("reset_drop", tmp, 32'd0);
    // three packets, the middle one matches
    wr(10'd2, 32'h0001157F);
    wr(10'd4, 32'd0);
    std_stream(0);
    check("t1_done", {31'b0, capture_done}, 32'd1);
    rd(10'd4, tmp); check("t1_rr", tmp, 32'd1);
    rd(10'd128, tmp); check("t1_w0", tmp, 32'h107F1547);
    rd(10'd129, tmp); check("t1_w1", tmp, 32'h07060504);
    rd(10'd174, tmp); check("t1_w46", tmp, 32'hBBBAB9B8);
    rd(10'd5, tmp); check("t1_drop", tmp, 32'd0);
    read_all();
    // same stream, valid only one cycle in four
    wr(10'd4, 32'd0);
    rd(10'd4, tmp); check("t2_rr_armed", tmp, 32'd0);
    std_stream(3);
    rd(10'd128, tmp); check("t2_w0", tmp, 32'h107F1547);
    rd(10'd174, tmp); check("t2_w46", tmp, 32'hBBBAB9B8);
    rd(10'd5, tmp); check("t2_drop", tmp, 32'd0);
    read_all();
    // sync loss at byte 100, new packet starts there
    wr(10'd4, 32'd0);
    build(13'h157F, 0); send(0, 99, 0);
    build(13'h157F, 1); send(0, 187, 0);
    drive(0, 0, 0);
    check("t3_done", {31'b0, capture_done}, 32'd1);
    rd(10'd5, tmp); check("t3_drop", tmp, 32'd1);
    rd(10'd129, tmp); check("t3_w1", tmp, 32'h5D5C5F5E);
    rd(10'd174, tmp); check("t3_w46", tmp, 32'hE1E0E3E2);
    // capture-any with pid_en=0
    wr(10'd2, 32'h0000157F);
    rd(10'd2, tmp); check("t4_pid", tmp, 32'h0000157F);
    wr(10'd4, 32'd0);
    build(13'h0000, 2); send(0, 187, 0);
    drive(0, 0, 0);
    check("t4_done", {31'b0, capture_done}, 32'd1);
    rd(10'd128, tmp); check("t4_w0", tmp, 32'h10000047);
    read_all();
    // re-arm mid capture
    wr(10'd2, 32'h0001157F);
    wr(10'd4, 32'd0);
    build(13'h157F, 0); send(0, 49, 0);
    wr(10'd4, 32'd0);
    rd(10'd4, tmp); check("t5_rr", tmp, 32'd0);
    rd(10'd5, tmp); check("t5_drop", tmp, 32'd1);
    build(13'h157F, 2); send(0, 187, 1);
    drive(0, 0, 0);
    check("t5_done", {31'b0, capture_done}, 32'd1);
    read_all();
    // reset mid capture
    wr(10'd4, 32'd0);
    build(13'h157F, 0); send(0, 80, 0);
    @(negedge clk); rst = 1; ts_valid = 0;
    @(negedge clk); rst = 0;
    check("t6_rdata", rdata, 32'd0);
    check("t6_done", {31'b0, capture_done}, 32'd0);
    rd(10'd4, tmp); check("t6_rr", tmp, 32'd0);
    build(13'h157F, 0); send(0, 187, 0);
    drive(0, 0, 0);
    check("t6_idle_done", {31'b0, capture_done}, 32'd0);
    rd(10'd4, tmp); check("t6_rr_idle", tmp, 32'd0);
    rd(10'd5, tmp); check("t6_drop", tmp, 32'd0);
    wr(10'd4, 32'd0);
    send(0, 187, 0);
    drive(0, 0, 0);
    rd(10'd4, tmp); check("t6_rr_rearm", tmp, 32'd1);
    // randomized stream with background reads, truncations and arms colliding with sync bytes
    rnd_rd = 1;
    wr(10'd2, 32'h0001157F);
    wr(10'd4, 32'd0);
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0)
        wr(10'd2, {15'b0, 1'($urandom_range(0, 1)), 3'b0, pids[$urandom_range(0, 2)]});
      if ($urandom_range(0, 4) == 0) wr(10'd4, 32'($urandom), 1, 1, 8'h47);
      build(pids[$urandom_range(0, 2)], 2);
      send(0, $urandom_range(0, 3) == 0 ? $urandom_range(1, 186) : 187, -1);
      if ($urandom_range(0, 3) == 0) send_byte(1, 8'($urandom), 0);
    end
    rnd_rd = 0;
    drive(0, 0, 0);
    rd(10'd4, tmp);
    rd(10'd5, tmp);
    read_all();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
